// File: rtl/thirty_two_bit_divide_if.sv
// Start/ready/exception handshake shared by the multiply and divide units.
// The controller (master) drives operands and the start strobe; the divider (slave) returns results.
interface thirty_two_bit_divide_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             do_div;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] remainder;
  logic             value_ready;
  logic             exception;
  logic             busy;

  modport master (
    output A, B, do_div,
    input  out, remainder, value_ready, exception, busy
  );

  modport slave (
    input  A, B, do_div,
    output out, remainder, value_ready, exception, busy
  );
endinterface

// File: rtl/thirty_two_bit_divide.sv
// Multi-cycle signed divider: restoring shift-subtract on magnitudes, one quotient bit per clock,
// followed by a sign fix-up (truncating quotient, remainder takes the dividend's sign).
//
// state | meaning
// IDLE  | no operation since reset
// RUN   | iterating; with counter at zero the next edge registers the result
// DONE  | result and flags held until do_div or reset
module thirty_two_bit_divide #(
  parameter int WIDTH = 32
) (
  input logic                  clk,
  input logic                  clrn,
  thirty_two_bit_divide_if.slave dif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvs_q, prem_q;
  logic [CW-1:0]    cnt_q;
  logic             sign_q_q, sign_r_q, dbz_q, ovf_q;
  logic [WIDTH-1:0] out_q, rem_q;
  logic             ready_q, exc_q;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic             b_zero, ovf_start;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial;
  logic             trial_ok;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    a_mag     = dif.A[WIDTH-1] ? -dif.A : dif.A;
    b_mag     = dif.B[WIDTH-1] ? -dif.B : dif.B;
    b_zero    = (dif.B == '0);
    ovf_start = (dif.A == INT_MIN) && (dif.B == '1);
    rem_shift = {prem_q, dvd_q[WIDTH-1]};
    // Extra borrow bit keeps the compare exact when |B| has its MSB set.
    trial     = {1'b0, rem_shift} - {2'b00, dvs_q};
    // A non-negative trial is always below |B|, so its top two bits are zero.
    trial_ok  = (trial[WIDTH+1:WIDTH] == 2'b00);
    q_fix     = sign_q_q ? -dvd_q : dvd_q;
    r_fix     = sign_r_q ? -prem_q : prem_q;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (dif.do_div)
      state_d = RUN;
    else if (state_q == RUN && cnt_q == '0)
      state_d = DONE;
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dvd_q    <= '0;
      dvs_q    <= '0;
      prem_q   <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
      out_q    <= '0;
      rem_q    <= '0;
      ready_q  <= 1'b0;
      exc_q    <= 1'b0;
    end else if (dif.do_div) begin
      dvd_q    <= a_mag;
      dvs_q    <= b_mag;
      // Divide-by-zero parks |A| in the remainder so the sign fix-up returns A unchanged.
      prem_q   <= b_zero ? a_mag : '0;
      cnt_q    <= b_zero ? '0 : CW'(WIDTH);
      sign_q_q <= dif.A[WIDTH-1] ^ dif.B[WIDTH-1];
      sign_r_q <= dif.A[WIDTH-1];
      dbz_q    <= b_zero;
      ovf_q    <= ovf_start;
      ready_q  <= 1'b0;
      exc_q    <= 1'b0;
    end else if (state_q == RUN) begin
      if (cnt_q != '0) begin
        prem_q <= trial_ok ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        dvd_q  <= {dvd_q[WIDTH-2:0], trial_ok};
        cnt_q  <= cnt_q - CW'(1);
      end else begin
        out_q   <= dbz_q ? '1 : q_fix;
        rem_q   <= r_fix;
        ready_q <= 1'b1;
        exc_q   <= dbz_q | ovf_q;
      end
    end
  end

  assign dif.out         = out_q;
  assign dif.remainder   = rem_q;
  assign dif.value_ready = ready_q;
  assign dif.exception   = exc_q;
  assign dif.busy        = (state_q == RUN);

endmodule
